// File: rtl/vga_timing_pkg.sv
// Shared types and default timings for the VGA timing generator.
//   phase_t     : phase of the horizontal and vertical timing FSMs
//   *_DEF       : 640x480 default timings (active/front porch/sync/back porch)
//   next_phase  : ACT -> FP -> SW -> BP -> ACT ordering
//   cnt_width   : bits needed for a phase counter running 0..n-1
//   max4        : largest of four lengths
package vga_timing_pkg;

  typedef enum logic [1:0] {ST_ACT, ST_FP, ST_SW, ST_BP} phase_t;

  localparam int H_ACT_DEF = 640;
  localparam int H_FP_DEF  = 16;
  localparam int H_SW_DEF  = 96;
  localparam int H_BP_DEF  = 48;
  localparam int V_ACT_DEF = 480;
  localparam int V_FP_DEF  = 10;
  localparam int V_SW_DEF  = 2;
  localparam int V_BP_DEF  = 33;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      ST_ACT:  return ST_FP;
      ST_FP:   return ST_SW;
      ST_SW:   return ST_BP;
      default: return ST_ACT;
    endcase
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_detect.sv
// Converts the clock divider's pixel toggle flag into a one-clk pixel tick.
// Every edge of pixel_toggle (rising or falling) is one tick. The history bit
// only samples while enable is high, so an edge arriving during a stall is
// reported on the first enabled clk.
//   clk, n_rst    : clock, asynchronous active-low reset
//   enable        : gates both sampling and the tick
//   restart       : synchronous clear of the history bit
//   pixel_toggle  : divider flag
//   pix_tick      : one-clk tick, combinational from pixel_toggle
module pixel_tick_detect (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic restart,
  input  logic pixel_toggle,
  output logic pix_tick
);

  logic tog_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       tog_q <= 1'b0;
    else if (restart) tog_q <= 1'b0;
    else if (enable)  tog_q <= pixel_toggle;
  end

  assign pix_tick = enable & (pixel_toggle ^ tog_q);

endmodule

// File: rtl/vga_timing_gen.sv
// Display timing generator. Walks horizontal and vertical phase FSMs one pixel
// tick at a time and registers sync, data-enable, coordinates and pulses.
//   clk, n_rst    : clock, asynchronous active-low reset
//   enable        : run; low holds all state and outputs
//   restart       : synchronous return to the pre-frame state (wins over a tick)
//   pixel_toggle  : divider flag, each transition is one pixel tick
//   hsync, vsync  : active-low syncs
//   de            : current pixel is in the active area
//   px_x, px_y    : active column/row, hold outside the active area
//   frame_start   : one-clk pulse when pixel (0,0) is presented
//   line_req      : one-clk pulse on hsync entry when the next line is active
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF,
  parameter int H_FP  = H_FP_DEF,
  parameter int H_SW  = H_SW_DEF,
  parameter int H_BP  = H_BP_DEF,
  parameter int V_ACT = V_ACT_DEF,
  parameter int V_FP  = V_FP_DEF,
  parameter int V_SW  = V_SW_DEF,
  parameter int V_BP  = V_BP_DEF,
  parameter int XW    = 10,
  parameter int YW    = 10
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          enable,
  input  logic          restart,
  input  logic          pixel_toggle,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] px_x,
  output logic [YW-1:0] px_y,
  output logic          frame_start,
  output logic          line_req
);

  localparam int HCW = cnt_width(max4(H_ACT, H_FP, H_SW, H_BP));
  localparam int VCW = cnt_width(max4(V_ACT, V_FP, V_SW, V_BP));

  logic           pix_tick;
  logic           started;
  phase_t         h_st, h_nxt, v_st, v_nxt;
  logic [HCW-1:0] hc, hc_nxt;
  logic [VCW-1:0] vc, vc_nxt;
  logic           h_wrap, frame_start_nxt, line_req_nxt;

  pixel_tick_detect u_tick (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .restart      (restart),
    .pixel_toggle (pixel_toggle),
    .pix_tick     (pix_tick)
  );

  function automatic logic [HCW-1:0] h_end(input phase_t p);
    case (p)
      ST_ACT:  return HCW'(H_ACT - 1);
      ST_FP:   return HCW'(H_FP - 1);
      ST_SW:   return HCW'(H_SW - 1);
      default: return HCW'(H_BP - 1);
    endcase
  endfunction

  function automatic logic [VCW-1:0] v_end(input phase_t p);
    case (p)
      ST_ACT:  return VCW'(V_ACT - 1);
      ST_FP:   return VCW'(V_FP - 1);
      ST_SW:   return VCW'(V_SW - 1);
      default: return VCW'(V_BP - 1);
    endcase
  endfunction

  // Next state assuming a tick happens; the register block decides whether to
  // take it. Until the first tick has presented (0,0) nothing advances.
  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    h_nxt  = h_st;
    hc_nxt = hc;
    v_nxt  = v_st;
    vc_nxt = vc;
    h_wrap = 1'b0;
    if (started) begin
      if (hc == h_end(h_st)) begin
        h_nxt  = next_phase(h_st);
        hc_nxt = '0;
        h_wrap = (h_st == ST_BP);
      end else begin
        hc_nxt = hc + HCW'(1);
      end
      if (h_wrap) begin
        if (vc == v_end(v_st)) begin
          v_nxt  = next_phase(v_st);
          vc_nxt = '0;
        end else begin
          vc_nxt = vc + VCW'(1);
        end
      end
    end
    frame_start_nxt = !started || (h_wrap && v_nxt == ST_ACT && vc_nxt == '0);
    // V does not move on hsync entry, so the current V position names this line.
    line_req_nxt = (h_st == ST_FP) && (h_nxt == ST_SW) &&
                   (((v_st == ST_ACT) && (vc < VCW'(V_ACT - 1))) ||
                    ((v_st == ST_BP) && (vc == VCW'(V_BP - 1))));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      started     <= 1'b0;
      h_st        <= ST_ACT;
      v_st        <= ST_ACT;
      hc          <= '0;
      vc          <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      frame_start <= 1'b0;
      line_req    <= 1'b0;
    end else if (restart) begin
      started     <= 1'b0;
      h_st        <= ST_ACT;
      v_st        <= ST_ACT;
      hc          <= '0;
      vc          <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      frame_start <= 1'b0;
      line_req    <= 1'b0;
    end else if (pix_tick) begin
      started     <= 1'b1;
      h_st        <= h_nxt;
      v_st        <= v_nxt;
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      hsync       <= (h_nxt != ST_SW);
      vsync       <= (v_nxt != ST_SW);
      de          <= (h_nxt == ST_ACT) && (v_nxt == ST_ACT);
      if (h_nxt == ST_ACT) px_x <= XW'(hc_nxt);
      if (v_nxt == ST_ACT) px_y <= YW'(vc_nxt);
      frame_start <= frame_start_nxt;
      line_req    <= line_req_nxt;
    end else begin
      frame_start <= 1'b0;
      line_req    <= 1'b0;
    end
  end

endmodule
